// File: rtl/bram_arb_pkg.sv
// Shared types for the two-port BRAM arbiter.
// Sweep/run states and port identifiers.
package bram_arb_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_id_t;

endpackage

// File: rtl/bram_sp.sv
// Single-port synchronous BRAM, one-cycle read latency.
// Read returns the word's contents before any same-cycle write.
module bram_sp #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/bram_arbiter.sv
// Two-port round-robin front end for a single-port BRAM.
// Zero-fills the memory after reset, then serves A/B requests.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata
);

  localparam state_t RST_ST =
    CLEAR_ON_RESET ? ST_INIT : ST_RUN;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic                    init_done_q, init_done_d;
  port_id_t                last_grant_q, last_grant_d;
  logic                    rsp_valid_q, rsp_valid_d;
  port_id_t                rsp_owner_q, rsp_owner_d;

  logic                    grant_a, grant_b;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == ST_RUN) begin
      grant_a = a_req_valid &&
        (!b_req_valid || last_grant_q == PORT_B);
      grant_b = b_req_valid &&
        (!a_req_valid || last_grant_q == PORT_A);
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    init_done_d  = init_done_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = grant_a | grant_b;
    rsp_owner_d  = grant_b ? PORT_B : PORT_A;
    mem_we       = 1'b0;
    mem_addr     = clr_addr_q;
    mem_wdata    = '0;
    unique case (state_q)
      ST_INIT: begin
        mem_we     = 1'b1;
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == '1) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        init_done_d = 1'b1;
        unique case (1'b1)
          grant_a: begin
            mem_we       = a_req_we;
            mem_addr     = a_req_addr;
            mem_wdata    = a_req_wdata;
            last_grant_d = PORT_A;
          end
          grant_b: begin
            mem_we       = b_req_we;
            mem_addr     = b_req_addr;
            mem_wdata    = b_req_wdata;
            last_grant_d = PORT_B;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RST_ST;
      clr_addr_q   <= '0;
      init_done_q  <= 1'b0;
      last_grant_q <= PORT_B;
      rsp_valid_q  <= 1'b0;
      rsp_owner_q  <= PORT_A;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      init_done_q  <= init_done_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_owner_q  <= rsp_owner_d;
    end
  end

  bram_sp #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (mem_we),
    .addr_i (mem_addr),
    .wdata_i(mem_wdata),
    .rdata_o(mem_rdata)
  );

  assign init_done   = init_done_q;
  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;
  assign a_rsp_valid = rsp_valid_q && rsp_owner_q == PORT_A;
  assign b_rsp_valid = rsp_valid_q && rsp_owner_q == PORT_B;
  assign a_rsp_rdata = mem_rdata;
  assign b_rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter (AW=4, DW=8).
// A negedge monitor models arbitration and scoreboards responses.
module tb_bram_arbiter;

  logic       clk;
  logic       rst_n;
  logic       init_done;
  logic       a_req_valid, a_req_ready, a_req_we;
  logic [3:0] a_req_addr;
  logic [7:0] a_req_wdata;
  logic       a_rsp_valid;
  logic [7:0] a_rsp_rdata;
  logic       b_req_valid, b_req_ready, b_req_we;
  logic [3:0] b_req_addr;
  logic [7:0] b_req_wdata;
  logic       b_rsp_valid;
  logic [7:0] b_rsp_rdata;

  int checks = 0;
  int errors = 0;

  bram_arbiter #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_done  (init_done),
    .a_req_valid(a_req_valid),
    .a_req_ready(a_req_ready),
    .a_req_we   (a_req_we),
    .a_req_addr (a_req_addr),
    .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid),
    .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid),
    .b_req_ready(b_req_ready),
    .b_req_we   (b_req_we),
    .b_req_addr (b_req_addr),
    .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid),
    .b_rsp_rdata(b_rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] m_mem [16];
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         pend_a, pend_b;
  bit         m_run, m_done, m_last_b;
  int         m_clr;

  always @(negedge clk) begin
    logic [7:0] e;
    bit ga, gb;
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      pend_a = 0;
      pend_b = 0;
      m_run = 0;
      m_done = 0;
      m_last_b = 1;
      m_clr = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      checks++;
      if (init_done !== 1'b0 || a_req_ready !== 1'b0 ||
          b_req_ready !== 1'b0 || a_rsp_valid !== 1'b0 ||
          b_rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_outs got done=%b ar=%b br=%b av=%b bv=%b want 0",
          init_done, a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid);
      end
    end else begin
      checks++;
      if (a_rsp_valid !== pend_a || b_rsp_valid !== pend_b) begin
        errors++;
        $display("FAIL rsp_valid got a=%b b=%b want a=%b b=%b",
          a_rsp_valid, b_rsp_valid, pend_a, pend_b);
      end
      if (pend_a) begin
        e = qa.pop_front();
        checks++;
        if (a_rsp_rdata !== e) begin
          errors++;
          $display("FAIL a_rdata got %h want %h", a_rsp_rdata, e);
        end
      end
      if (pend_b) begin
        e = qb.pop_front();
        checks++;
        if (b_rsp_rdata !== e) begin
          errors++;
          $display("FAIL b_rdata got %h want %h", b_rsp_rdata, e);
        end
      end
      pend_a = 0;
      pend_b = 0;
      checks++;
      if (init_done !== m_done) begin
        errors++;
        $display("FAIL init_done got %b want %b", init_done, m_done);
      end
      if (!m_run) begin
        checks++;
        if (a_req_ready !== 1'b0 || b_req_ready !== 1'b0) begin
          errors++;
          $display("FAIL init_ready got a=%b b=%b want 0 0",
            a_req_ready, b_req_ready);
        end
        if (m_clr == 15) begin
          m_run = 1;
          m_done = 1;
        end
        m_clr++;
      end else begin
        ga = a_req_valid && (!b_req_valid || m_last_b);
        gb = b_req_valid && (!a_req_valid || !m_last_b);
        checks++;
        if (a_req_ready !== ga || b_req_ready !== gb) begin
          errors++;
          $display("FAIL grant got a=%b b=%b want a=%b b=%b",
            a_req_ready, b_req_ready, ga, gb);
        end
        if (ga) begin
          qa.push_back(m_mem[a_req_addr]);
          if (a_req_we) m_mem[a_req_addr] = a_req_wdata;
          m_last_b = 0;
          pend_a = 1;
        end else if (gb) begin
          qb.push_back(m_mem[b_req_addr]);
          if (b_req_we) m_mem[b_req_addr] = b_req_wdata;
          m_last_b = 1;
          pend_b = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(bit v, bit we, logic [3:0] ad, logic [7:0] d);
    a_req_valid = v;
    a_req_we    = we;
    a_req_addr  = ad;
    a_req_wdata = d;
  endtask

  task automatic drive_b(bit v, bit we, logic [3:0] ad, logic [7:0] d);
    b_req_valid = v;
    b_req_we    = we;
    b_req_addr  = ad;
    b_req_wdata = d;
  endtask

  task automatic wait_done(string tag);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (init_done === 1'b1) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout got init_done=%b want 1", tag, init_done);
    end
  endtask

  task automatic read_all_a();
    tick();
    for (int i = 0; i < 16; i++) begin
      drive_a(1, 0, 4'(i), 8'h00);
      tick();
    end
    drive_a(0, 0, 4'h0, 8'h00);
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) tick();
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (init_done !== 1'b0 || a_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL sweep_cyc%0d got done=%b rdy=%b want 0 0",
          i, init_done, a_req_ready);
      end
    end
    @(negedge clk);
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL sweep_len got init_done=%b want 1", init_done);
    end
    read_all_a();
  endtask

  task automatic test_single_a();
    drive_a(1, 1, 4'd5, 8'h3C);
    @(negedge clk);
    checks++;
    if (a_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL a_wr_ready got %b want 1", a_req_ready);
    end
    tick();
    drive_a(1, 0, 4'd5, 8'h00);
    @(negedge clk);
    checks++;
    if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL a_rd_ready got rdy=%b ack=%b want 1 1",
        a_req_ready, a_rsp_valid);
    end
    tick();
    drive_a(0, 0, 4'd0, 8'h00);
    @(negedge clk);
    checks++;
    if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL a_rd_data got v=%b d=%h want 1 3c",
        a_rsp_valid, a_rsp_rdata);
    end
    tick();
  endtask

  task automatic test_round_robin();
    drive_b(1, 0, 4'd3, 8'h00);
    tick();
    drive_b(0, 0, 4'd0, 8'h00);
    tick();
    drive_a(1, 0, 4'd5, 8'h00);
    drive_b(1, 0, 4'd3, 8'h00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (a_req_ready !== (i % 2 == 0) ||
          b_req_ready !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL rr_grant%0d got a=%b b=%b want a=%b b=%b",
          i, a_req_ready, b_req_ready, i % 2 == 0, i % 2 == 1);
      end
      if (i > 0) begin
        checks++;
        if (a_rsp_valid !== (i % 2 == 1) ||
            b_rsp_valid !== (i % 2 == 0)) begin
          errors++;
          $display("FAIL rr_rsp%0d got a=%b b=%b", i,
            a_rsp_valid, b_rsp_valid);
        end
      end
      tick();
    end
    drive_a(0, 0, 4'd0, 8'h00);
    drive_b(0, 0, 4'd0, 8'h00);
    tick();
    tick();
  endtask

  task automatic test_raw();
    drive_a(1, 1, 4'd7, 8'h11);
    tick();
    drive_a(0, 0, 4'd0, 8'h00);
    drive_b(1, 0, 4'd7, 8'h00);
    tick();
    drive_b(0, 0, 4'd0, 8'h00);
    @(negedge clk);
    checks++;
    if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 8'h11) begin
      errors++;
      $display("FAIL raw_b got v=%b d=%h want 1 11",
        b_rsp_valid, b_rsp_rdata);
    end
    tick();
    drive_a(1, 1, 4'd7, 8'h22);
    tick();
    drive_a(0, 0, 4'd0, 8'h00);
    @(negedge clk);
    checks++;
    if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 8'h11) begin
      errors++;
      $display("FAIL rbw_ack got v=%b d=%h want 1 11",
        a_rsp_valid, a_rsp_rdata);
    end
    tick();
  endtask

  task automatic test_init_hold();
    bit ok = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    drive_b(1, 0, 4'd5, 8'h00);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (init_done === 1'b1) begin
        ok = 1;
        break;
      end
      checks++;
      if (b_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_ready%0d got %b want 0", i, b_req_ready);
      end
    end
    checks++;
    if (!ok || b_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_first got done=%b rdy=%b want 1 1",
        init_done, b_req_ready);
    end
    tick();
    drive_b(0, 0, 4'd0, 8'h00);
    @(negedge clk);
    checks++;
    if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL hold_rsp got v=%b d=%h want 1 00",
        b_rsp_valid, b_rsp_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (m_clr == 9) begin
        ok = 1;
        break;
      end
    end
    #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_sweep_timeout got clr=%0d want 9", m_clr);
    end
    rst_n = 0;
    @(negedge clk);
    checks++;
    if (init_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_sweep_done got %b want 0", init_done);
    end
    tick();
    rst_n = 1;
    wait_done("mid_sweep");
    tick();
    drive_a(1, 1, 4'd2, 8'h55);
    tick();
    drive_a(1, 0, 4'd2, 8'h00);
    tick();
    drive_a(0, 0, 4'd0, 8'h00);
    rst_n = 0;
    @(negedge clk);
    checks++;
    if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0 ||
        init_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_read got av=%b bv=%b done=%b want 0 0 0",
        a_rsp_valid, b_rsp_valid, init_done);
    end
    tick();
    rst_n = 1;
    wait_done("mid_read");
    read_all_a();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    drive_a(0, 0, 4'd0, 8'h00);
    drive_b(0, 0, 4'd0, 8'h00);
    test_reset();
    test_single_a();
    test_round_robin();
    test_raw();
    test_init_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
